// File: rtl/key_pulse_pkg.sv
// ----------------------------------------------------------------------------
// key_pulse_pkg
//
// Purpose:
//    Shared constants and types for the push-button conditioner.
//    - Default timing constants for a 50 MHz CLOCK_50.
//    - State type of the per-key press/repeat FSM.
//    - Helper functions that size the per-key counters.
//
// Ports:
//    (package, no ports)
// ----------------------------------------------------------------------------
package key_pulse_pkg;

    // Default timings at 50 MHz: 20 ms debounce, 500 ms to first repeat,
    // then 100 ms between repeats.
    localparam int KEY_DEBOUNCE     = 1000000;
    localparam int KEY_REPEAT_DELAY = 25000000;
    localparam int KEY_REPEAT_RATE  = 5000000;

    // By default only the val_add and val_sub keys (bits 2 and 3) auto-repeat.
    localparam logic [3:0] KEY_REPEAT_MASK = 4'b1100;

    // Per-key press/repeat FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        DELAY  = 2'd2,
        REPEAT = 2'd3
    } key_state_t;

    // Largest of three counts; the debounce and repeat counters share one width.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width for a terminal count of max_count-1. The counters clear at
    // terminal count, so $clog2 is enough; never let it collapse to zero bits.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/key_pulse_debounce.sv
// ----------------------------------------------------------------------------
// key_pulse_debounce
//
// Purpose:
//    Conditions a single raw push-button.
//    - Two-flop synchroniser, then inversion so that 1 means pressed.
//    - Counter-based debounce that produces the accepted level.
//    - Press/repeat FSM that emits a one-cycle event strobe on each accepted
//      press and, if REPEAT_EN is set, on each auto-repeat while held.
//
// Ports:
//    clk      in   1   system clock
//    rst_n    in   1   asynchronous active-low reset
//    key_raw  in   1   raw button, active-low, asynchronous to clk
//    level    out  1   debounced pressed state, active-high
//    strobe   out  1   one-cycle event, aligned with the cycle level rises
// ----------------------------------------------------------------------------
module key_pulse_debounce
    import key_pulse_pkg::*;
#(
    parameter int DEBOUNCE     = KEY_DEBOUNCE,
    parameter int REPEAT_DELAY = KEY_REPEAT_DELAY,
    parameter int REPEAT_RATE  = KEY_REPEAT_RATE,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic level,
    output logic strobe
);

    localparam int CNT_W = cnt_width(max3(DEBOUNCE, REPEAT_DELAY, REPEAT_RATE));

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [1:0]       sync_q;
    logic             pressed;
    logic             level_q;
    logic [CNT_W-1:0] deb_cnt;
    logic             differ;
    logic             accept;
    logic             rise;
    logic             fall;

    key_state_t       state;
    key_state_t       state_next;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_next;
    logic             strobe_next;

    // Two-flop synchroniser. The flops reset to 1 (released), so a key held
    // through reset is seen as a fresh press and goes through the full
    // debounce again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    assign pressed = ~sync_q[1];

    // Debounce decode. 'accept' is the cycle in which the synced value has
    // differed from the accepted level for DEBOUNCE consecutive cycles; the
    // level flips on the following edge. rise/fall come out of the same
    // decode so the FSM reacts on the same edge the level changes.
    always_comb begin
        differ = (pressed != level_q);
        accept = differ && (deb_cnt == DEB_LAST);
        rise   = accept && pressed;
        fall   = accept && !pressed;
    end

    // Debounce counter and accepted level. Any cycle where synced and level
    // agree restarts the count, so a bounce shorter than DEBOUNCE is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            deb_cnt <= '0;
        end else if (accept) begin
            level_q <= pressed;
            deb_cnt <= '0;
        end else if (differ) begin
            deb_cnt <= deb_cnt + 1'b1;
        end else begin
            deb_cnt <= '0;
        end
    end

    assign level = level_q;

    // Press/repeat FSM state register. The strobe is registered alongside it
    // only in the sense that it is decoded combinationally from the current
    // state and counter; see the next-state block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rep_cnt <= '0;
        end else begin
            state   <= state_next;
            rep_cnt <= rep_next;
        end
    end

    // Next-state and event decode. A release (fall) overrides everything,
    // including a repeat expiry in the same cycle, so no event escapes after
    // the key has been let go.
    always_comb begin
        state_next  = state;
        rep_next    = rep_cnt;
        strobe_next = 1'b0;

        case (state)
            IDLE: begin
                rep_next = '0;
                if (rise) begin
                    strobe_next = 1'b1;
                    state_next  = REPEAT_EN ? DELAY : HOLD;
                end
            end
            HOLD: begin
                rep_next = '0;
            end
            DELAY: begin
                if (rep_cnt == DELAY_LAST) begin
                    strobe_next = 1'b1;
                    rep_next    = '0;
                    state_next  = REPEAT;
                end else begin
                    rep_next = rep_cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (rep_cnt == RATE_LAST) begin
                    strobe_next = 1'b1;
                    rep_next    = '0;
                end else begin
                    rep_next = rep_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                rep_next   = '0;
            end
        endcase

        if (fall) begin
            state_next  = IDLE;
            rep_next    = '0;
            strobe_next = 1'b0;
        end
    end

    assign strobe = strobe_next;

endmodule

// File: rtl/key_pulse.sv
// ----------------------------------------------------------------------------
// key_pulse
//
// Purpose:
//    Input-side conditioner for the board push-buttons. Each raw active-low
//    KEY is synchronised, debounced and turned into a sticky event request
//    (press) that stays up until the consumer acknowledges it, so a slowly
//    clocked consumer never misses a press. Selected keys auto-repeat while
//    held. overrun flags that an event merged into one still pending.
//
// Ports:
//    CLOCK_50  in   1       system clock, the only clock
//    reset     in   1       asynchronous active-low reset
//    KEY       in   N_KEYS  raw buttons, active-low, asynchronous
//    ack       in   N_KEYS  consumer acknowledge, one per key
//    press     out  N_KEYS  sticky event request, active-high
//    level     out  N_KEYS  debounced pressed state, active-high
//    overrun   out  N_KEYS  sticky: event arrived while press was pending
// ----------------------------------------------------------------------------
module key_pulse
    import key_pulse_pkg::*;
#(
    parameter int                N_KEYS       = 4,
    parameter int                DEBOUNCE     = KEY_DEBOUNCE,
    parameter int                REPEAT_DELAY = KEY_REPEAT_DELAY,
    parameter int                REPEAT_RATE  = KEY_REPEAT_RATE,
    parameter logic [N_KEYS-1:0] REPEAT_MASK  = KEY_REPEAT_MASK
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] KEY,
    input  logic [N_KEYS-1:0] ack,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] overrun
);

    logic [N_KEYS-1:0] strobe;

    // One independent conditioner per key; only the repeat enable differs.
    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_pulse_debounce #(
            .DEBOUNCE     (DEBOUNCE),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_key (
            .clk     (CLOCK_50),
            .rst_n   (reset),
            .key_raw (KEY[i]),
            .level   (level[i]),
            .strobe  (strobe[i])
        );
    end

    // Event/acknowledge handshake, bitwise per key. A new event always wins
    // over an ack in the same cycle, so an event is never lost. An event that
    // lands on a still-pending, unacknowledged request merges into it and
    // latches overrun until the next reset.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            press   <= '0;
            overrun <= '0;
        end else begin
            press   <= strobe | (press & ~ack);
            overrun <= overrun | (strobe & press & ~ack);
        end
    end

endmodule

// File: tb/tb_key_pulse.sv
// ----------------------------------------------------------------------------
// tb_key_pulse
//
// Purpose:
//    Self-checking bench for key_pulse with short timings (DEBOUNCE=4,
//    REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_MASK=4'b1100). A behavioural
//    model derives press/level/overrun from how long each key has been held,
//    and a compare process checks the DUT against it every cycle. Directed
//    scenarios pin exact cycle timings with literal expectations; a random
//    phase then drives bouncy keys and random acks.
// ----------------------------------------------------------------------------
module tb_key_pulse;

    localparam int         DEB  = 4;
    localparam int         RD   = 10;
    localparam int         RR   = 3;
    localparam logic [3:0] MASK = 4'b1100;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key;
    logic [3:0] ack;
    logic [3:0] press;
    logic [3:0] level;
    logic [3:0] overrun;

    int errors = 0;
    int checks = 0;

    key_pulse #(
        .N_KEYS       (4),
        .DEBOUNCE     (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .REPEAT_MASK  (MASK)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .KEY      (key),
        .ack      (ack),
        .press    (press),
        .level    (level),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [3:0] mPress   = '0;
    logic [3:0] mLevel   = '0;
    logic [3:0] mOverrun = '0;
    logic [3:0] mSeen1   = '1;
    logic [3:0] mSeen2   = '1;
    int         mRun[4];
    int         mHeld[4];

    // Reference model. The key is visible two edges after it is sampled.
    // A level change is accepted after DEB consecutive disagreeing cycles.
    // Events fire at hold time 0, and for repeating keys at RD, RD+RR, ...
    initial begin
        logic synced;
        logic changed;
        logic fire;
        for (int i = 0; i < 4; i++) begin
            mRun[i]  = 0;
            mHeld[i] = 0;
        end
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mPress   = '0;
                mLevel   = '0;
                mOverrun = '0;
                mSeen1   = '1;
                mSeen2   = '1;
                for (int i = 0; i < 4; i++) begin
                    mRun[i]  = 0;
                    mHeld[i] = 0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    synced  = !mSeen2[i];
                    changed = 1'b0;
                    fire    = 1'b0;
                    if (synced != mLevel[i]) begin
                        mRun[i]++;
                        if (mRun[i] == DEB) begin
                            mLevel[i] = synced;
                            mRun[i]   = 0;
                            changed   = 1'b1;
                        end
                    end else begin
                        mRun[i] = 0;
                    end
                    if (changed && mLevel[i]) begin
                        mHeld[i] = 0;
                        fire     = 1'b1;
                    end else if (!changed && mLevel[i]) begin
                        mHeld[i]++;
                        if (MASK[i] && (mHeld[i] == RD ||
                            (mHeld[i] > RD && (mHeld[i] - RD) % RR == 0)))
                            fire = 1'b1;
                    end
                    if (fire) begin
                        if (mPress[i] && !ack[i])
                            mOverrun[i] = 1'b1;
                        mPress[i] = 1'b1;
                    end else if (ack[i]) begin
                        mPress[i] = 1'b0;
                    end
                    mSeen2[i] = mSeen1[i];
                    mSeen1[i] = key[i];
                end
            end
        end
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    // Drive inputs right after a falling edge.
    task automatic applyStimulus(input logic [3:0] k, input logic [3:0] a);
        key = k;
        ack = a;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Continuous model comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("cyc_press",   press,   mPress);
            checkOutput("cyc_level",   level,   mLevel);
            checkOutput("cyc_overrun", overrun, mOverrun);
        end
    end

    // Directed scenarios followed by randomized stimulus.
    initial begin
        int         rises[$];
        int         expRise[7];
        logic       prevPress;
        logic [3:0] k;

        expRise = '{6, 16, 19, 22, 25, 28, 31};

        // Scenario 1: reset with all keys released.
        reset = 1'b1;
        applyStimulus(4'hF, 4'h0);
        #1 reset = 1'b0;
        tick(3);
        checkOutput("rst_press",   press,   4'h0);
        checkOutput("rst_level",   level,   4'h0);
        checkOutput("rst_overrun", overrun, 4'h0);
        reset = 1'b1;
        tick(50);
        checkOutput("idle_press",   press,   4'h0);
        checkOutput("idle_level",   level,   4'h0);
        checkOutput("idle_overrun", overrun, 4'h0);

        // Scenario 2: non-repeating key held 30 cycles.
        applyStimulus(4'b1110, 4'h0);
        tick(5);
        checkOutput("k0_level_t5", level[0], 1'b0);
        tick(1);
        checkOutput("k0_level_t6", level[0], 1'b1);
        checkOutput("k0_press_t6", press[0], 1'b1);
        tick(24);
        checkOutput("k0_press_held",   press[0],   1'b1);
        checkOutput("k0_overrun_held", overrun[0], 1'b0);
        applyStimulus(4'b1110, 4'b0001);
        tick(1);
        applyStimulus(4'b1110, 4'h0);
        checkOutput("k0_press_acked", press[0], 1'b0);
        applyStimulus(4'hF, 4'h0);
        tick(8);
        checkOutput("k0_level_rel", level[0], 1'b0);
        checkOutput("k0_press_rel", press[0], 1'b0);

        // Scenario 3: bounce on key 1.
        applyStimulus(4'b1101, 4'h0);
        tick(3);
        applyStimulus(4'hF, 4'h0);
        tick(1);
        applyStimulus(4'b1101, 4'h0);
        checkOutput("k1_bounce_press", press[1], 1'b0);
        checkOutput("k1_bounce_level", level[1], 1'b0);
        tick(5);
        checkOutput("k1_level_t5", level[1], 1'b0);
        tick(1);
        checkOutput("k1_level_t6", level[1], 1'b1);
        checkOutput("k1_press_t6", press[1], 1'b1);
        applyStimulus(4'b1101, 4'b0010);
        tick(1);
        applyStimulus(4'hF, 4'h0);
        tick(8);
        checkOutput("k1_press_rel", press[1], 1'b0);

        // Scenario 4: auto-repeat on key 2, each event acked promptly.
        applyStimulus(4'b1011, 4'h0);
        prevPress = 1'b0;
        k = 4'b1011;
        for (int n = 1; n <= 45; n++) begin
            tick(1);
            if (press[2] && !prevPress)
                rises.push_back(n);
            prevPress = press[2];
            if (n == 31) checkOutput("k2_level_n31", level[2], 1'b1);
            if (n == 32) checkOutput("k2_level_n32", level[2], 1'b0);
            if (n == 26) k = 4'hF;
            applyStimulus(k, press[2] ? 4'b0100 : 4'h0);
        end
        applyStimulus(4'hF, 4'h0);
        checkOutput("k2_rise_count", rises.size(), 7);
        for (int j = 0; j < 7; j++)
            checkOutput($sformatf("k2_rise_%0d", j),
                        (j < rises.size()) ? rises[j] : -1, expRise[j]);
        checkOutput("k2_overrun", overrun[2], 1'b0);

        // Scenario 5: ack coinciding with a repeat event, then overrun.
        applyStimulus(4'b0111, 4'h0);
        tick(6);
        checkOutput("k3_press_t6", press[3], 1'b1);
        tick(9);
        applyStimulus(4'b0111, 4'b1000);
        tick(1);
        applyStimulus(4'b0111, 4'h0);
        checkOutput("k3_press_ackev",   press[3],   1'b1);
        checkOutput("k3_overrun_ackev", overrun[3], 1'b0);
        tick(3);
        checkOutput("k3_overrun_set", overrun[3], 1'b1);
        applyStimulus(4'hF, 4'h0);
        tick(20);
        checkOutput("k3_overrun_sticky", overrun[3], 1'b1);
        applyStimulus(4'hF, 4'b1000);
        tick(1);
        applyStimulus(4'hF, 4'h0);
        checkOutput("k3_press_acked",   press[3],   1'b0);
        checkOutput("k3_overrun_kept",  overrun[3], 1'b1);

        // Scenario 6: reset while key 2 is repeating, key held through it.
        applyStimulus(4'b1011, 4'h0);
        tick(20);
        #2 reset = 1'b0;
        #1;
        checkOutput("r6_press",   press,   4'h0);
        checkOutput("r6_level",   level,   4'h0);
        checkOutput("r6_overrun", overrun, 4'h0);
        tick(2);
        reset = 1'b1;
        tick(5);
        checkOutput("r6_press_t5", press[2], 1'b0);
        tick(1);
        checkOutput("r6_press_t6", press[2], 1'b1);
        checkOutput("r6_level_t6", level[2], 1'b1);
        applyStimulus(4'b1011, 4'b0100);
        tick(1);
        applyStimulus(4'b1011, 4'h0);
        tick(8);
        checkOutput("r6_press_t15", press[2], 1'b0);
        tick(1);
        checkOutput("r6_press_t16", press[2], 1'b1);
        applyStimulus(4'hF, 4'hF);
        tick(10);
        applyStimulus(4'hF, 4'h0);

        // Randomized phase: bouncy keys of varied hold length, random acks,
        // one mid-run reset. Checked by the compare process.
        k = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 15) == 0)
                    k[b] = ~k[b];
            applyStimulus(k, 4'($urandom & $urandom));
            if (c == 1500) begin
                #2 reset = 1'b0;
                tick(2);
                reset = 1'b1;
            end else begin
                tick(1);
            end
        end

        applyStimulus(4'hF, 4'h0);
        tick(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
